ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting)
// to a PS/2 mouse or keyboard over open-drain clk/data, sampling the device-generated clock.

---
 rtl/ps2_host_tx.sv | 133 +++++++++++++
 tb/tb_ps2_host_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one byte from the host to a PS/2 device over open-drain clock and data.
// The device clock is synchronised and glitch-filtered, and the whole transfer is bounded by a timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 840,
  parameter int TIMEOUT_CYC = 140000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, FINISH} state_t;
  state_t          state_q, state_d;
  logic [1:0]      csync_q, csync_d, dsync_q, dsync_d;
  logic            lvl_q, lvl_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [9:0]      sr_q, sr_d;
  logic [3:0]      nbit_q, nbit_d;
  logic            nack_q, nack_d, clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic            flip, fall, timing;

  always_comb begin
    csync_d   = {csync_q[0], ps2clk_in};
    dsync_d   = {dsync_q[0], ps2data_in};
    flip      = (csync_q[1] != lvl_q) && (fcnt_q == FLT_LAST);
    lvl_d     = lvl_q ^ flip;
    fcnt_d    = (csync_q[1] != lvl_q && !flip) ? fcnt_q + 1'b1 : '0;
    fall      = flip & lvl_q;
    timing    = state_q inside {SEND, ACK, RELEASE};
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = timing ? tmo_q + 1'b1 : tmo_q;
    sr_d      = sr_q;
    nbit_d    = nbit_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    case (state_q)
      IDLE: if (tx_start) begin
        sr_d     = {1'b1, ~^tx_data, tx_data};
        clk_oe_d = 1'b1;
        cnt_d    = '0;
        nack_d   = 1'b0;
        state_d  = INHIBIT;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        clk_oe_d = 1'b0;
        tmo_d    = '0;
        nbit_d   = '0;
        state_d  = SEND;
      end
      SEND: if (fall) begin
        data_oe_d = ~sr_q[0];
        sr_d      = sr_q >> 1;
        nbit_d    = nbit_q + 1'b1;
        state_d   = (nbit_q == 4'd9) ? ACK : SEND;
      end
      ACK: if (fall) begin
        nack_d  = dsync_q[1];
        state_d = RELEASE;
      end
      RELEASE: state_d = (lvl_q && dsync_q[1]) ? FINISH : RELEASE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A stalled device must never leave the bus held or the host waiting.
    if (timing && tmo_q == TMO_LAST) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      nack_d    = 1'b1;
      state_d   = FINISH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      csync_q   <= '1;
      dsync_q   <= '1;
      lvl_q     <= 1'b1;
      fcnt_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      sr_q      <= '0;
      nbit_q    <= '0;
      nack_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      csync_q   <= csync_d;
      dsync_q   <= dsync_d;
      lvl_q     <= lvl_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      sr_q      <= sr_d;
      nbit_q    <= nbit_d;
      nack_q    <= nack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign busy       = (state_q != IDLE) && (state_q != FINISH);
  assign done       = state_q == FINISH;
  assign error      = done & nack_q;
  assign ps2clk_oe  = clk_oe_q;
  assign ps2data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model driving the clock.
module tb_ps2_host_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2clk_oe, ps2data_oe;
  logic       bfm_clk = 1'b1;
  logic       bfm_data = 1'b1;
  logic       ps2clk_in, ps2data_in;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;

  assign ps2clk_in  = ~ps2clk_oe & bfm_clk;
  assign ps2data_in = ~ps2data_oe & bfm_data;

  ps2_host_tx #(.INHIBIT_CYC(50), .TIMEOUT_CYC(5000), .FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic half(input logic lvl, input bit g);
    for (int c = 0; c < 20; c++) begin
      bfm_clk = (g && (c == 8 || c == 9)) ? ~lvl : lvl;
      @(negedge clk);
    end
    bfm_clk = lvl;
  endtask

  task automatic bfm_xfer(input bit ack, input bit glitch, input int abort_at,
                          output logic [9:0] got, output int inh, output logic stb);
    int t = 0;
    inh = 0;
    got = '0;
    while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && t < 3000) begin
      if (ps2clk_oe === 1'b1) inh++;
      @(negedge clk);
      t++;
    end
    chk("req_seen", {31'd0, t < 3000}, 32'd1);
    stb = ps2data_in;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == abort_at) begin
        bfm_clk = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2data_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        bfm_clk = 1'b1;
        return;
      end
      half(1'b0, glitch && i < 10);
      bfm_clk = 1'b1;
      if (i < 10) got[i] = ps2data_in;
      if (i == 10) begin
        bfm_data = 1'b1;
        return;
      end
      if (i == 9 && ack) begin
        repeat (10) @(negedge clk);
        bfm_data = 1'b0;
        repeat (10) @(negedge clk);
      end else half(1'b1, glitch);
    end
  endtask

  task automatic wait_done(output logic d, output logic e);
    int t = 0;
    while (done !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    d = done;
    e = error;
  endtask

  initial begin
    logic [9:0] got;
    int         inh, n, dc;
    logic       stb, d, e;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    chk("reset_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
    chk("reset_data_oe", {31'd0, ps2data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xF4 with ACK: odd parity bit is 0
    start(8'hF4);
    chk("f4_busy", {31'd0, busy}, 32'd1);
    bfm_xfer(1'b1, 1'b0, -1, got, inh, stb);
    chk("f4_inhibit_len", {31'd0, inh >= 50 && inh <= 51}, 32'd1);
    chk("f4_start_bit", {31'd0, stb}, 32'd0);
    chk("f4_frame", {22'd0, got}, 32'h2F4);
    wait_done(d, e);
    chk("f4_done", {31'd0, d}, 32'd1);
    chk("f4_error", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("f4_done_pulse", {31'd0, done}, 32'd0);
    chk("f4_busy_end", {31'd0, busy}, 32'd0);
    chk("f4_done_cnt", done_cnt, 32'd1);

    // 0xFF without ACK: parity 1, error reported; tx_start in the done cycle is dropped
    start(8'hFF);
    bfm_xfer(1'b0, 1'b0, -1, got, inh, stb);
    chk("ff_frame", {22'd0, got}, 32'h3FF);
    wait_done(d, e);
    chk("ff_done", {31'd0, d}, 32'd1);
    chk("ff_error", {31'd0, e}, 32'd1);
    start(8'h55);
    chk("finish_start_ignored", {31'd0, busy}, 32'd0);
    chk("ff_done_cnt", done_cnt, 32'd2);

    // device never clocks: timeout exactly 5000 cycles after clock release
    start(8'h12);
    n = 0;
    while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_req_seen", {31'd0, n < 3000}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 32'd5000);
    chk("tmo_error", {31'd0, error}, 32'd1);
    chk("tmo_clk_oe", {31'd0, ps2clk_oe}, 32'd0);
    chk("tmo_data_oe", {31'd0, ps2data_oe}, 32'd0);
    @(negedge clk);

    // short glitches on the device clock are filtered out
    start(8'h5A);
    bfm_xfer(1'b1, 1'b1, -1, got, inh, stb);
    chk("glitch_frame", {22'd0, got}, 32'h35A);
    wait_done(d, e);
    chk("glitch_done", {31'd0, d}, 32'd1);
    chk("glitch_error", {31'd0, e}, 32'd0);
    @(negedge clk);

    // a second tx_start while busy is ignored
    dc = done_cnt;
    start(8'hC3);
    repeat (10) @(negedge clk);
    start(8'h00);
    bfm_xfer(1'b1, 1'b0, -1, got, inh, stb);
    chk("restart_frame", {22'd0, got}, 32'h3C3);
    wait_done(d, e);
    chk("restart_error", {31'd0, e}, 32'd0);
    repeat (150) @(negedge clk);
    chk("restart_one_done", done_cnt - dc, 32'd1);
    chk("restart_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of bit 4, then a clean transfer
    dc = done_cnt;
    start(8'h00);
    bfm_xfer(1'b1, 1'b0, 4, got, inh, stb);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 32'd0);
    start(8'hAA);
    bfm_xfer(1'b1, 1'b0, -1, got, inh, stb);
    chk("aa_frame", {22'd0, got}, 32'h3AA);
    wait_done(d, e);
    chk("aa_done", {31'd0, d}, 32'd1);
    chk("aa_error", {31'd0, e}, 32'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
